// File: rtl/cordic_rotation_sequencer.sv
// -----------------------------------------------------------------------------
// cordic_rotation_sequencer
//
// Iterative CORDIC rotation-mode controller. One shared add/shift stage is
// reused for ITERATIONS clock cycles per operation. In each cycle the rotation
// direction comes from the sign of the residual angle z (zero counts as
// positive). The per-iteration arctangent step is read from a constant table
// that is built from the parameters at elaboration time. The result is not
// gain-compensated, so x/y outputs carry the CORDIC gain K ~ 1.6468.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   operation request, sampled only while busy = 0
//   x_in      in   initial x, signed
//   y_in      in   initial y, signed
//   z_in      in   rotation angle, signed binary angle (2^(BIT_WIDTH-1) = pi)
//   busy      out  operation in progress
//   done      out  one-cycle pulse, x/y/z_out valid
//   x_out     out  final x (scaled by K)
//   y_out     out  final y (scaled by K)
//   z_out     out  residual angle
//   iter_idx  out  current iteration index (debug)
//   di_out    out  current direction, 1 = +1 (z >= 0), 0 = -1 (z < 0)
// -----------------------------------------------------------------------------
module cordic_rotation_sequencer #(
    parameter int BIT_WIDTH  = 16,
    parameter int ITERATIONS = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [BIT_WIDTH-1:0]              x_in,
    input  logic [BIT_WIDTH-1:0]              y_in,
    input  logic [BIT_WIDTH-1:0]              z_in,
    output logic                              busy,
    output logic                              done,
    output logic [BIT_WIDTH-1:0]              x_out,
    output logic [BIT_WIDTH-1:0]              y_out,
    output logic [BIT_WIDTH-1:0]              z_out,
    output logic [$clog2(ITERATIONS+1)-1:0]   iter_idx,
    output logic                              di_out
);

    localparam int IW    = $clog2(ITERATIONS + 1);
    // Table padded to a power of two so every iter_idx value addresses an entry.
    localparam int LUT_N = 2 ** IW;
    // pi scaled by 2^61.
    localparam logic [63:0] PI_Q61 = 64'h6487_ED51_10B4_611A;

    // round(atan(2^-i) / pi * 2^(BIT_WIDTH-1)), evaluated only at elaboration.
    // For i >= 1 the argument is a power of two, so the Taylor series
    // atan(t) = t - t^3/3 + t^5/5 - ... reduces to shifted divisions in Q62.
    function automatic logic [BIT_WIDTH-1:0] atan_entry(input int i);
        logic [63:0] acc;
        logic [63:0] term;
        logic [63:0] denom;
        logic [63:0] quot;
        int          sh;
        acc = 64'd0;
        if (i == 0) begin
            // atan(1) = pi/4, i.e. exactly a quarter of the half-circle scale.
            acc = 64'd1 << (BIT_WIDTH - 3);
            return BIT_WIDTH'(acc);
        end else begin
            for (int k = 0; k < 32; k++) begin
                sh = 62 - i * (2 * k + 1);
                if (sh >= 0) begin
                    term = (64'd1 << sh) / 64'(2 * k + 1);
                    if (k[0]) begin
                        acc = acc - term;
                    end else begin
                        acc = acc + term;
                    end
                end else begin
                    acc = acc;
                end
            end
            denom = PI_Q61 >> (BIT_WIDTH - 2);
            quot  = (acc + (denom >> 1)) / denom;
            return BIT_WIDTH'(quot);
        end
    endfunction

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ROTATE = 1'b1
    } state_t;

    state_t                       state_q;
    logic signed [BIT_WIDTH-1:0]  x_q;
    logic signed [BIT_WIDTH-1:0]  y_q;
    logic signed [BIT_WIDTH-1:0]  z_q;
    logic signed [BIT_WIDTH-1:0]  x_d;
    logic signed [BIT_WIDTH-1:0]  y_d;
    logic signed [BIT_WIDTH-1:0]  z_d;
    logic signed [BIT_WIDTH-1:0]  x_sh_s;
    logic signed [BIT_WIDTH-1:0]  y_sh_s;
    logic signed [BIT_WIDTH-1:0]  atan_s;
    logic signed [BIT_WIDTH-1:0]  atan_lut_s [LUT_N];
    logic [IW-1:0]                iter_q;
    logic                         busy_q;
    logic                         done_q;
    logic [BIT_WIDTH-1:0]         x_out_q;
    logic [BIT_WIDTH-1:0]         y_out_q;
    logic [BIT_WIDTH-1:0]         z_out_q;
    logic                         di_s;
    logic                         last_s;

    // Constant arctangent table; unused padding entries are zero.
    for (genvar g = 0; g < LUT_N; g++) begin : g_atan
        if (g < ITERATIONS) begin : g_used
            localparam logic [BIT_WIDTH-1:0] ENTRY = atan_entry(g);
            assign atan_lut_s[g] = ENTRY;
        end else begin : g_pad
            assign atan_lut_s[g] = {BIT_WIDTH{1'b0}};
        end
    end

    // Shared micro-rotation stage: direction from the sign of live z.
    always_comb begin
        di_s   = ~z_q[BIT_WIDTH-1];
        x_sh_s = x_q >>> iter_q;
        y_sh_s = y_q >>> iter_q;
        atan_s = atan_lut_s[iter_q];
        last_s = (iter_q == IW'(ITERATIONS - 1));
        if (di_s) begin
            x_d = x_q - y_sh_s;
            y_d = y_q + x_sh_s;
            z_d = z_q - atan_s;
        end else begin
            x_d = x_q + y_sh_s;
            y_d = y_q - x_sh_s;
            z_d = z_q + atan_s;
        end
    end

    // Sequencer FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= {BIT_WIDTH{1'b0}};
            y_q     <= {BIT_WIDTH{1'b0}};
            z_q     <= {BIT_WIDTH{1'b0}};
            iter_q  <= {IW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_out_q <= {BIT_WIDTH{1'b0}};
            y_out_q <= {BIT_WIDTH{1'b0}};
            z_out_q <= {BIT_WIDTH{1'b0}};
        end else begin
            // done is a single-cycle pulse unless re-armed below.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q     <= x_in;
                        y_q     <= y_in;
                        z_q     <= z_in;
                        iter_q  <= {IW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= S_ROTATE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ROTATE: begin
                    x_q    <= x_d;
                    y_q    <= y_d;
                    z_q    <= z_d;
                    iter_q <= iter_q + IW'(1);
                    if (last_s) begin
                        x_out_q <= x_d;
                        y_out_q <= y_d;
                        z_out_q <= z_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_ROTATE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign x_out    = x_out_q;
    assign y_out    = y_out_q;
    assign z_out    = z_out_q;
    assign iter_idx = iter_q;
    // Direction follows the live residual angle, not a registered copy.
    assign di_out   = di_s;

endmodule

// File: tb/tb_cordic_rotation_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cordic_rotation_sequencer (BIT_WIDTH=16, 12 iters).
// Accepted operations push an expected result into a scoreboard queue; the
// monitor pops and compares when done pulses. Expected values come from an
// integer reference of the rotation recurrence (arctan table from $atan) plus
// a real-valued recurrence driven by the same direction sequence.
// -----------------------------------------------------------------------------
module tb_cordic_rotation_sequencer;

    localparam int  BW = 16;
    localparam int  IT = 12;
    localparam int  IW = $clog2(IT + 1);
    localparam real PI = 3.14159265358979323846;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic signed [BW-1:0]  x_in;
    logic signed [BW-1:0]  y_in;
    logic signed [BW-1:0]  z_in;
    logic                  busy;
    logic                  done;
    logic signed [BW-1:0]  x_out;
    logic signed [BW-1:0]  y_out;
    logic signed [BW-1:0]  z_out;
    logic [IW-1:0]         iter_idx;
    logic                  di_out;

    cordic_rotation_sequencer #(.BIT_WIDTH(BW), .ITERATIONS(IT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .busy     (busy),
        .done     (done),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out),
        .iter_idx (iter_idx),
        .di_out   (di_out)
    );

    typedef struct {
        logic signed [BW-1:0] x;
        logic signed [BW-1:0] y;
        logic signed [BW-1:0] z;
        logic [IT-1:0]        di;
        real                  xr;
        real                  yr;
        int                   acc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp;
    int          n_bad;
    int          cyc;
    logic        prev_rst_low;
    logic        armed;
    logic [47:0] hold_xyz;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used for latency and iteration-index expectations.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Zero when within tolerance, otherwise the rounded absolute error.
    function automatic longint tol_err(input longint got, input real ideal, input int tol);
        real e;
        e = real'(got) - ideal;
        if (e < 0.0) e = -e;
        if (e <= real'(tol)) return 0;
        return longint'(e);
    endfunction

    function automatic int atan_ref(input int i);
        return $rtoi($floor($atan(2.0 ** (-i)) / PI * 32768.0 + 0.5));
    endfunction

    // Reference recurrence: exact integer path and real-valued path.
    function automatic exp_t model(input logic signed [BW-1:0] xi,
                                   input logic signed [BW-1:0] yi,
                                   input logic signed [BW-1:0] zi);
        exp_t                 e;
        logic signed [BW-1:0] x, y, z, xn, yn;
        real                  xr, yr, xr2, t;
        x = xi; y = yi; z = zi;
        xr = real'(xi); yr = real'(yi);
        e.di = '0;
        for (int i = 0; i < IT; i++) begin
            t = 2.0 ** (-i);
            if (z[BW-1] == 1'b0) begin
                e.di[i] = 1'b1;
                xn  = x - (y >>> i);
                yn  = y + (x >>> i);
                z   = z - 16'(atan_ref(i));
                xr2 = xr - yr * t;
                yr  = yr + xr * t;
            end else begin
                xn  = x + (y >>> i);
                yn  = y - (x >>> i);
                z   = z + 16'(atan_ref(i));
                xr2 = xr + yr * t;
                yr  = yr - xr * t;
            end
            x = xn; y = yn; xr = xr2;
        end
        e.x = x; e.y = y; e.z = z; e.xr = xr; e.yr = yr; e.acc = 0;
        return e;
    endfunction

    // Monitor: reset values, scoreboard pops on done, per-cycle di/iter, hold.
    initial begin
        prev_rst_low = 1'b0;
        armed        = 1'b0;
        hold_xyz     = '0;
    end
    always @(negedge clk) begin
        exp_t e;
        int   ix;
        if (prev_rst_low) begin
            armed = 1'b1;
            check_value("rst_busy", busy, 0);
            check_value("rst_done", done, 0);
            check_value("rst_out", {x_out, y_out, z_out}, 0);
            check_value("rst_iter", iter_idx, 0);
            check_value("rst_di", di_out, 1);
            hold_xyz = '0;
        end else if (armed) begin
            if (done) begin
                check_value("done_has_op", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_value("x_exact", x_out, e.x);
                    check_value("y_exact", y_out, e.y);
                    check_value("z_exact", z_out, e.z);
                    check_value("latency", cyc - e.acc, IT);
                    check_value("done_busy", busy, 0);
                    check_value("x_real", tol_err(x_out, e.xr, IT), 0);
                    check_value("y_real", tol_err(y_out, e.yr, IT), 0);
                    hold_xyz = {e.x, e.y, e.z};
                end
            end else begin
                check_value("hold", {x_out, y_out, z_out}, hold_xyz);
                if (busy) begin
                    check_value("busy_has_op", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        ix = cyc - sb[0].acc;
                        check_value("iter", iter_idx, ix);
                        if (ix >= 0 && ix < IT) check_value("di", di_out, sb[0].di[ix]);
                    end
                end
            end
        end
        prev_rst_low = ~rst_n;
        if (!rst_n) begin
            sb.delete();
        end else if (armed && start && !busy) begin
            e     = model(x_in, y_in, z_in);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
    end

    task automatic start_op(input int xa, input int ya, input int za);
        x_in  = 16'(xa);
        y_in  = 16'(ya);
        z_in  = 16'(za);
        start = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 40 && busy; t++) @(negedge clk);
        check_value("accept_to", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int seen;
        seen = 0;
        for (int t = 0; t < 30 && seen == 0; t++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check_value("done_to", seen, 1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Stimulus sequence.
    initial begin
        int tmp;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b1;
        x_in  = 16'sd10000;
        y_in  = 16'sd0;
        z_in  = 16'sd0;

        // Reset held 3 clocks with start high; op accepted right after release.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_done();
        check_value("t2_x", tol_err(x_out, 16468.0, 12), 0);
        check_value("t2_y", tol_err(y_out, 0.0, 12), 0);
        check_value("t2_z", tol_err(z_out, 0.0, 5), 0);
        next_cycle();

        // +90 and -90 degree rotations.
        start_op(10000, 0, 16384);
        wait_done();
        check_value("t3p_x", tol_err(x_out, 0.0, 12), 0);
        check_value("t3p_y", tol_err(y_out, 16468.0, 12), 0);
        check_value("t3p_z", tol_err(z_out, 0.0, 5), 0);
        next_cycle();
        start_op(10000, 0, -16384);
        wait_done();
        check_value("t3n_x", tol_err(x_out, 0.0, 12), 0);
        check_value("t3n_y", tol_err(y_out, -16468.0, 12), 0);
        next_cycle();

        // start held high: back-to-back ops while inputs change every cycle.
        start = 1'b1;
        for (int c = 0; c < 45; c++) begin
            tmp  = int'($urandom_range(12000)) - 6000;
            x_in = 16'(tmp);
            tmp  = int'($urandom_range(12000)) - 6000;
            y_in = 16'(tmp);
            tmp  = int'($urandom_range(32000)) - 16000;
            z_in = 16'(tmp);
            next_cycle();
        end
        start = 1'b0;
        for (int t = 0; t < 20 && (busy || done); t++) next_cycle();
        next_cycle();

        // Abort at iteration 5, then a clean operation.
        start_op(7000, -2000, 5000);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        repeat (20) next_cycle();
        start_op(7000, -2000, 5000);
        wait_done();
        next_cycle();

        // Angle sweep against the reference models.
        for (int z = -16384; z <= 16384; z += 1024) begin
            start_op(9000, 3000, z);
            wait_done();
            next_cycle();
        end

        // Outside the convergence range: must still complete.
        start_op(4000, 1000, -30000);
        wait_done();
        repeat (3) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
